// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters (core, DMA), the arbiter and the
// memory macro. The master view belongs to the arbiter; the slave view is
// the environment that drives requests and returns memory read data.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // core port
  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          c_ack;
  logic [DW-1:0] c_rdata;
  // DMA / loader port
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  // memory macro side
  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  // status
  logic          busy;
  logic          owner;

  modport master (
    input  c_req, c_we, c_addr, c_wdata,
    output c_ack, c_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_ack, d_rdata,
    output m_en, m_we, m_addr, m_wdata,
    input  m_rdata,
    output busy, owner
  );

  modport slave (
    output c_req, c_we, c_addr, c_wdata,
    input  c_ack, c_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_ack, d_rdata,
    input  m_en, m_we, m_addr, m_wdata,
    output m_rdata,
    input  busy, owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous memory.
// One access at a time: IDLE picks a winner, ISSUE strobes the memory,
// WAIT counts out the read latency, ACK pulses the winner's acknowledge.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1   // 1..7
) (
  input  logic           clk,
  input  logic           rst,
  mem_port_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  // Counter preload; the last WAIT cycle is the one where cnt is 1.
  localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

  state_t        state_reg, state_next;
  logic [2:0]    cnt_reg;
  logic          last_reg;
  logic          owner_reg;
  logic          we_reg;
  logic [AW-1:0] addr_reg;
  logic [DW-1:0] wdata_reg;
  logic [DW-1:0] c_rdata_reg;
  logic [DW-1:0] d_rdata_reg;

  logic          grant_valid;
  logic          grant_sel;
  logic          capture;

  // Winner selection: a lone requester wins; on a tie the port that did not
  // win last time goes next.
  assign grant_valid = bus.c_req | bus.d_req;
  assign grant_sel   = (bus.c_req & bus.d_req) ? ~last_reg : bus.d_req;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and the read-data capture strobe.
  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (grant_valid) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (LAT_M1 == 3'd0) begin
          capture    = 1'b1;
          state_next = ACK;
        end else begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (cnt_reg == 3'd1) begin
          capture    = 1'b1;
          state_next = ACK;
        end
      end
      ACK: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Latch the winner's request fields at the grant; later changes on the
  // request inputs are ignored until the next IDLE decision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_reg <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else if (state_reg == IDLE && grant_valid) begin
      owner_reg <= grant_sel;
      we_reg    <= grant_sel ? bus.d_we    : bus.c_we;
      addr_reg  <= grant_sel ? bus.d_addr  : bus.c_addr;
      wdata_reg <= grant_sel ? bus.d_wdata : bus.c_wdata;
    end
  end

  // Latency counter: preloaded in ISSUE, counts down through WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= 3'd0;
    end else if (state_reg == ISSUE) begin
      cnt_reg <= LAT_M1;
    end else if (state_reg == WAIT) begin
      cnt_reg <= cnt_reg - 3'd1;
    end
  end

  // Read data lands only in the owner's register; the other port's data is
  // left untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_rdata_reg <= '0;
      d_rdata_reg <= '0;
    end else if (capture) begin
      if (owner_reg) begin
        d_rdata_reg <= bus.m_rdata;
      end else begin
        c_rdata_reg <= bus.m_rdata;
      end
    end
  end

  // Remember who was served last for the round-robin tie break; reset
  // favours the core on the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_reg <= 1'b1;
    end else if (state_reg == ACK) begin
      last_reg <= owner_reg;
    end
  end

  // Outputs decoded from state; address and write data stay parked on the
  // latched values between accesses.
  assign bus.m_en    = (state_reg == ISSUE);
  assign bus.m_we    = (state_reg == ISSUE) & we_reg;
  assign bus.m_addr  = addr_reg;
  assign bus.m_wdata = wdata_reg;
  assign bus.c_ack   = (state_reg == ACK) & ~owner_reg;
  assign bus.d_ack   = (state_reg == ACK) &  owner_reg;
  assign bus.c_rdata = c_rdata_reg;
  assign bus.d_rdata = d_rdata_reg;
  assign bus.busy    = (state_reg != IDLE);
  assign bus.owner   = owner_reg;

endmodule
